// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared FSM state encoding for the countdown timer.
package countdown_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic expiry, done pulse and status flags.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int MAX = 15,
    localparam int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d, load_sat;
    logic             done_q, done_d;

    assign load_sat = (int'(load_value) > MAX) ? MAX_W : load_value;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            reload_d = load_sat;
            count_d  = load_sat;
            state_d  = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start) begin
            case (state_q)
                IDLE:    state_d = (count_q != '0) ? RUN : IDLE;
                EXPIRED: begin
                    state_d = (reload_q != '0) ? RUN : EXPIRED;
                    count_d = (reload_q != '0) ? reload_q : count_q;
                end
                default: count_d = reload_q;
            endcase
        end else if (state_q == RUN && enable) begin
            // Expiry on the 1 -> 0 tick; periodic mode skips 0 and reloads directly.
            if (count_q > 1) begin
                count_d = count_q - 1'b1;
            end else begin
                done_d  = 1'b1;
                count_d = reload_mode ? reload_q : '0;
                state_d = reload_mode ? RUN : EXPIRED;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer (MAX=15, plus a MAX=10 copy for saturation).
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       reset, load, start, stop, enable, reload_mode;
    logic [3:0] load_value;
    logic [3:0] count, count2;
    logic       busy, done, expired, busy2, done2, expired2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.MAX(15)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start),
        .stop(stop), .enable(enable), .reload_mode(reload_mode),
        .count(count), .busy(busy), .done(done), .expired(expired)
    );

    // A 4-bit port cannot carry 20, so saturation is exercised on a MAX=10 instance.
    countdown_timer #(.MAX(10)) dut2 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start),
        .stop(stop), .enable(enable), .reload_mode(reload_mode),
        .count(count2), .busy(busy2), .done(done2), .expired(expired2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int d, input int e);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".expired"}, 32'(expired), 32'(e));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        enable = 1'b0; reload_mode = 1'b0; load_value = 4'd0;
        #3;
        chk_all("reset", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 0, 0);

        load = 1'b1; load_value = 4'd5;
        tick();
        load = 1'b0;
        chk_all("os_load", 5, 0, 0, 0);
        start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os_start", 5, 1, 0, 0);
        for (int k = 4; k >= 1; k--) begin
            tick();
            chk_all("os_tick", k, 1, 0, 0);
        end
        tick();
        chk_all("os_expire", 0, 0, 1, 1);
        tick();
        chk_all("os_after", 0, 0, 0, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("os_stop_noeffect", 0, 0, 0, 1);

        enable = 1'b0; load = 1'b1; load_value = 4'd3;
        tick();
        load = 1'b0; start = 1'b1; reload_mode = 1'b1;
        tick();
        start = 1'b0;
        chk_all("per_start", 3, 1, 0, 0);
        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_all("per_tick", (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0, 0);
        end
        enable = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0; reload_mode = 1'b0;
        chk_all("per_stop", 3, 0, 0, 0);

        load = 1'b1; load_value = 4'd12;
        tick();
        chk("sat12_max15", 32'(count), 32'd12);
        chk("sat12_max10", 32'(count2), 32'd10);
        load_value = 4'd15;
        tick();
        load = 1'b0;
        chk("sat15_max15", 32'(count), 32'd15);
        chk("sat15_max10", 32'(count2), 32'd10);

        load = 1'b1; load_value = 4'd0;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("zero_start", 0, 0, 0, 0);

        load = 1'b1; load_value = 4'd4;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("en_start", 4, 1, 0, 0);
        enable = 1'b1;
        tick();
        chk_all("en_1", 3, 1, 0, 0);
        enable = 1'b0;
        tick();
        chk_all("en_0", 3, 1, 0, 0);
        enable = 1'b1;
        tick();
        chk_all("en_1b", 2, 1, 0, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("en_stop", 2, 0, 0, 0);
        tick();
        chk_all("en_idle_hold", 2, 0, 0, 0);
        enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("en_resume", 2, 1, 0, 0);
        enable = 1'b1;
        tick();
        chk_all("en_res_1", 1, 1, 0, 0);
        tick();
        chk_all("en_res_exp", 0, 0, 1, 1);
        enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("exp_restart", 4, 1, 0, 0);

        load = 1'b1; load_value = 4'd7; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk_all("load_start", 7, 0, 0, 0);

        load = 1'b1; load_value = 4'd10;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        repeat (4) tick();
        chk_all("rst_pre", 6, 1, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("rst_release", 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("rst_nostart", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX, default 15: largest loadable count value; MAX SHALL be >= 1.
REQ-002 Localparam WIDTH SHALL equal $clog2(MAX+1), so that MAX is always representable.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  capture load_value into the reload register and the count.
REQ-006 load_value  input  WIDTH  value to load.
REQ-007 start  input  1  begin or restart the countdown.
REQ-008 stop  input  1  abort the countdown and hold the count.
REQ-009 enable  input  1  count-tick qualifier; the count decrements only on cycles where enable is high.
REQ-010 reload_mode  input  1  1 = periodic (auto-reload on expiry); 0 = one-shot.
REQ-011 count  output  WIDTH  present count value (registered).
REQ-012 busy  output  1  high while state is RUN.
REQ-013 done  output  1  one-cycle pulse on each expiry (registered).
REQ-014 expired  output  1  high while state is EXPIRED.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and EXPIRED.
REQ-016 Command priority within a cycle SHALL be load > stop > start; lower-priority commands in the same cycle are ignored.
REQ-017 load (any state): the reload register and count SHALL take min(load_value, MAX), the state SHALL go to IDLE, and done SHALL be 0 next cycle.
REQ-018 stop in RUN: the state SHALL go to IDLE with count held; stop in IDLE or EXPIRED has no effect.
REQ-019 start in IDLE with count != 0: the state SHALL go to RUN with count unchanged.
REQ-020 start in IDLE with count == 0: no effect.
REQ-021 start in EXPIRED: if the reload register != 0, the count SHALL be set to the reload register and the state SHALL go to RUN; otherwise no effect.
REQ-022 start in RUN: the count SHALL be set to the reload register (restart); the state stays RUN.
REQ-023 RUN, enable=1, count > 1: the count SHALL decrement by 1.
REQ-024 RUN, enable=1, count == 1: done SHALL be 1 next cycle.
  - reload_mode=1: the count SHALL become the reload register and the state stays RUN.
  - reload_mode=0: the count SHALL become 0 and the state SHALL go to EXPIRED.
REQ-025 RUN, enable=0: the count and state SHALL hold.
REQ-026 done SHALL be high for exactly one cycle per expiry and 0 in every other cycle.
REQ-027 The count SHALL never wrap below 0 or exceed MAX.
REQ-028 Latency: count, busy, expired and done SHALL reflect a command or tick on the first clock edge after it is sampled.
REQ-029 Periodic mode with reload value N SHALL produce one done pulse per N enabled cycles.

Reset
REQ-030 reset high SHALL immediately force: state IDLE, count 0, reload register 0, busy 0, done 0, expired 0.
REQ-031 Reset asserted during RUN SHALL abort without a done pulse; operation resumes only after a new load and start.

Structure
REQ-032 The state enum typedef (IDLE, RUN, EXPIRED) SHALL be defined in a shared package countdown_timer_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the FSM and datapath are small enough to stay together.
REQ-034 busy and expired SHALL be decoded directly from the state register.

Verification (MAX=15)
REQ-035 Bench SHALL cover:
  - Load 5, start, enable held high, reload_mode=0: count reads 5,4,3,2,1,0; done pulses once as the count reaches 0; expired=1 afterwards.
  - Load 3, start, reload_mode=1, enable high for 9 cycles: done pulses on cycles 3, 6 and 9; count reloads to 3 after each pulse; busy stays 1.
  - Load 20: count reads 15 (saturated).
  - Load 0 then start: no change, stays IDLE.
  - Count at 4 in RUN, enable toggled 1,0,1: count reads 3,3,2; stop then gives IDLE with count 2; a later start resumes from 2.
  - Same-cycle load=1 (value 7) and start=1: count 7, state IDLE.
  - Reset asserted mid-RUN at count 6: all outputs 0 immediately and no done pulse.
